// File: rtl/ace_snoop_sequencer_pkg.sv
// Shared types for the coherent snoop sequencer: CR response layout, AC payload types, FSM states.
package ace_snoop_sequencer_pkg;

    localparam int unsigned NB_CORES     = 4;
    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned CRRESP_WIDTH = 5;

    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] prot_t;

    // Bit 0 is DataTransfer, bit 4 is WasUnique.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } snoop_seq_state_e;

endpackage

// File: rtl/ace_snoop_sequencer_lzc.sv
// Lowest-set-bit finder (trailing-zero count); returns 0 when no bit is set.
module ace_snoop_sequencer_lzc #(
    parameter int unsigned Width    = 4,
    parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o
);

    // Scan downwards so the lowest set index is written last.
    always_comb begin
        cnt_o = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CntWidth'(i);
            end
        end
    end

endmodule

// File: rtl/ace_snoop_sequencer.sv
// Broadcasts one AC snoop to every non-initiating core, collects the CR responses
// and presents a single aggregated result upstream.
module ace_snoop_sequencer
    import ace_snoop_sequencer_pkg::*;
#(
    parameter int unsigned NbCores   = NB_CORES,
    parameter int unsigned AddrWidth = ADDR_WIDTH,
    parameter int unsigned IdxWidth  = (NbCores > 1) ? $clog2(NbCores) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_addr_i,
    input  acsnoop_t                     req_snoop_i,
    input  prot_t                        req_prot_i,
    input  logic [IdxWidth-1:0]          req_initiator_i,
    output logic [NbCores-1:0]           ac_valid_o,
    input  logic [NbCores-1:0]           ac_ready_i,
    output logic [AddrWidth-1:0]         ac_addr_o,
    output acsnoop_t                     ac_snoop_o,
    output prot_t                        ac_prot_o,
    input  logic [NbCores-1:0]           cr_valid_i,
    output logic [NbCores-1:0]           cr_ready_o,
    input  logic [NbCores*CRRESP_WIDTH-1:0] cr_resp_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic                         rsp_data_o,
    output logic [IdxWidth-1:0]          rsp_owner_o,
    output logic                         rsp_shared_o,
    output logic                         rsp_dirty_o,
    output logic                         rsp_unique_o,
    output logic                         rsp_error_o
);

    snoop_seq_state_e       state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    acsnoop_t               snoop_q, snoop_d;
    prot_t                  prot_q, prot_d;
    logic [NbCores-1:0]     tgt_mask_q, tgt_mask_d;
    logic [NbCores-1:0]     ac_sent_q, ac_sent_d;
    logic [NbCores-1:0]     cr_got_q, cr_got_d;
    logic [NbCores-1:0]     data_mask_q, data_mask_d;
    logic                   shared_q, shared_d;
    logic                   dirty_q, dirty_d;
    logic                   unique_q, unique_d;
    logic                   error_q, error_d;

    logic [NbCores-1:0]     ac_hs;
    logic [NbCores-1:0]     cr_hs;
    crresp_t                cr_resp;

    // Handshake-facing outputs decode straight from registers: no request-to-AC path.
    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign ac_valid_o   = tgt_mask_q & ~ac_sent_q;
    assign cr_ready_o   = ac_sent_q & ~cr_got_q;
    assign ac_addr_o    = addr_q;
    assign ac_snoop_o   = snoop_q;
    assign ac_prot_o    = prot_q;
    assign rsp_data_o   = |data_mask_q;
    assign rsp_shared_o = shared_q;
    assign rsp_dirty_o  = dirty_q;
    assign rsp_unique_o = unique_q;
    assign rsp_error_o  = error_q;

    assign ac_hs = ac_valid_o & ac_ready_i;
    assign cr_hs = cr_ready_o & cr_valid_i;

    ace_snoop_sequencer_lzc #(
        .Width    (NbCores),
        .CntWidth (IdxWidth)
    ) i_owner_lzc (
        .in_i  (data_mask_q),
        .cnt_o (rsp_owner_o)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        prot_d      = prot_q;
        tgt_mask_d  = tgt_mask_q;
        ac_sent_d   = ac_sent_q;
        cr_got_d    = cr_got_q;
        data_mask_d = data_mask_q;
        shared_d    = shared_q;
        dirty_d     = dirty_q;
        unique_d    = unique_q;
        error_d     = error_q;
        cr_resp     = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    snoop_d     = req_snoop_i;
                    prot_d      = req_prot_i;
                    // An out-of-range initiator matches no index, so every core is snooped.
                    for (int i = 0; i < int'(NbCores); i++) begin
                        tgt_mask_d[i] = (IdxWidth'(i) != req_initiator_i);
                    end
                    ac_sent_d   = '0;
                    cr_got_d    = '0;
                    data_mask_d = '0;
                    shared_d    = 1'b0;
                    dirty_d     = 1'b0;
                    unique_d    = 1'b0;
                    error_d     = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                ac_sent_d = ac_sent_q | ac_hs;
                cr_got_d  = cr_got_q | cr_hs;
                for (int i = 0; i < int'(NbCores); i++) begin
                    if (cr_hs[i]) begin
                        cr_resp        = crresp_t'(cr_resp_i[CRRESP_WIDTH*i +: CRRESP_WIDTH]);
                        data_mask_d[i] = cr_resp.data_transfer;
                        shared_d       = shared_d | cr_resp.is_shared;
                        dirty_d        = dirty_d  | cr_resp.pass_dirty;
                        unique_d       = unique_d | cr_resp.was_unique;
                        error_d        = error_d  | cr_resp.error;
                    end
                end
                if ((cr_got_q | cr_hs) == tgt_mask_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            prot_q      <= '0;
            tgt_mask_q  <= '0;
            ac_sent_q   <= '0;
            cr_got_q    <= '0;
            data_mask_q <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            unique_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snoop_q     <= snoop_d;
            prot_q      <= prot_d;
            tgt_mask_q  <= tgt_mask_d;
            ac_sent_q   <= ac_sent_d;
            cr_got_q    <= cr_got_d;
            data_mask_q <= data_mask_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
            unique_q    <= unique_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: doc/ace_snoop_sequencer.md
Name: ace_snoop_sequencer

Overview:
- Sequences one coherent snoop transaction at a time for the culsans coherence path.
- Accepts a snoop request (address, ACE AC snoop type, initiating core) and broadcasts it on the AC channel to every core except the initiator.
- Collects each target's CR response and returns one aggregated result (data owner, shared, dirty, error) to the upstream coherence logic.
- Sits between the ACE request decoder and the per-core snoop ports.

Parameters:
- NbCores, culsans_pkg::NB_CORES, number of snooped cores (2..4).
- AddrWidth, culsans_pkg::AddrWidth, snoop address width.
- IdxWidth, (NbCores > 1) ? $clog2(NbCores) : 1, core index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  snoop request valid
- req_ready_o  out  1  request accepted (high only in IDLE)
- req_addr_i  in  AddrWidth  snoop address
- req_snoop_i  in  4  ace_pkg::acsnoop_t type
- req_prot_i  in  3  axi_pkg::prot_t
- req_initiator_i  in  IdxWidth  requesting core, excluded from the broadcast
- ac_valid_o  out  NbCores  per-core AC valid
- ac_ready_i  in  NbCores  per-core AC ready
- ac_addr_o  out  AddrWidth  latched address, shared by all cores
- ac_snoop_o  out  4  latched snoop type
- ac_prot_o  out  3  latched prot
- cr_valid_i  in  NbCores  per-core CR valid
- cr_ready_o  out  NbCores  per-core CR ready
- cr_resp_i  in  NbCores*5  per-core CRRESP, core i at bits [5i+4:5i]
- rsp_valid_o  out  1  aggregated result valid
- rsp_ready_i  in  1  result consumed
- rsp_data_o  out  1  at least one target had DataTransfer
- rsp_owner_o  out  IdxWidth  lowest-index target with DataTransfer; 0 if none
- rsp_shared_o  out  1  OR of IsShared
- rsp_dirty_o  out  1  OR of PassDirty
- rsp_unique_o  out  1  OR of WasUnique
- rsp_error_o  out  1  OR of Error

Behaviour:
- CRRESP bit order: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- Reset:
  - state IDLE.
  - All masks and aggregate registers 0.
  - All outputs 0 except req_ready_o=1.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch addr/snoop/prot.
  - tgt_mask = all ones with bit req_initiator_i cleared.
  - ac_sent=0, cr_got=0, aggregates cleared.
  - Go to BUSY next cycle. No combinational path from request to ac_valid_o.
- State BUSY:
  - ac_valid_o[i] = tgt_mask[i] & ~ac_sent[i].
  - ac_sent[i] sets on ac_valid_o[i] & ac_ready_i[i].
  - Each core completes its AC independently; no ordering between cores.
  - Once asserted, ac_valid_o[i] stays high and AC payload is stable until its handshake.
  - cr_ready_o[i] = ac_sent[i] & ~cr_got[i]. A CR arriving in the same cycle as its own AC handshake is not accepted; it is taken the following cycle.
  - cr_valid_i on non-target cores, or before AC was sent, is ignored.
  - On each CR handshake: cr_got[i] sets and the resp bits are OR-ed into the aggregates.
  - rsp_owner_o keeps the lowest index with DataTransfer, regardless of response arrival order.
  - When (cr_got | CR handshakes this cycle) == tgt_mask, go to RESP.
- State RESP:
  - rsp_valid_o=1; rsp_* fields stable.
  - On rsp_ready_i: go to IDLE. req_ready_o is 1 the cycle after, so there is no back-to-back acceptance in the RESP->IDLE cycle.
- Latency: request handshake at cycle 0 -> ac_valid_o at cycle 1. If all targets are ready and answer one cycle after AC, rsp_valid_o is at cycle 3.
- Only one transaction is in flight; no request queueing.
- If req_initiator_i >= NbCores, no bit is cleared and all cores are snooped.
- Asynchronous reset mid-transaction aborts it:
  - outputs return to reset values immediately.
  - in-flight CRs are dropped; cores must be reset together.
- The block has no timeout.

Decomposition:
- culsans_pkg gains:
  - crresp_t packed struct {was_unique, is_shared, pass_dirty, error, data_transfer}.
  - snoop_seq_state_e enum {IDLE, BUSY, RESP}.
- ace_pkg::acsnoop_t and axi_pkg::prot_t are reused as is.
- One sub-module is natural: lzc-style lowest-set-bit finder for owner selection (reuse common_cells lzc, mode trailing).

Test Plan:
- NbCores=2, initiator=0, snoop=ReadShared (0x1), addr=0x8010_0040:
  - ac_valid_o=2'b10 at cycle 1.
  - Core1 CR resp=5'b01001 (IsShared|DataTransfer) -> rsp_data=1, owner=1, shared=1, dirty=0.
- NbCores=4, initiator=2, cores 0/1/3 ready at cycles 1/3/5, CR in order 3,0,1:
  - ac_valid_o starts 4'b1011.
  - rsp_valid only after the last CR.
  - rsp_valid held until rsp_ready_i.
- NbCores=4, initiator=0, cores 3 and 1 both return DataTransfer|PassDirty (5'b00101):
  - owner=1, dirty=1, data=1.
  - Core 2 returns 5'b00000.
- Backpressure:
  - Hold ac_ready_i[1]=0 for 10 cycles -> ac_valid_o[1], ac_addr_o, ac_snoop_o stable throughout.
  - cr_ready_o[1]=0 until the AC handshake.
- Stray traffic:
  - cr_valid_i asserted on the initiator and in IDLE -> never accepted.
  - Aggregates unaffected.
  - req_valid_i during BUSY -> req_ready_o=0.
- Reset mid-BUSY with one CR collected:
  - All outputs 0 and req_ready_o=1 immediately.
  - A new request then completes with clean aggregates (error=0).
